// File: rtl/uart_tx_arbiter.sv
// Two-requester, frame-granular round-robin arbiter in front of a byte UART.
// A granted requester owns the UART until its last byte has finished transmitting.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ack,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] bytes_sent
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             prio_q, prio_d;
  logic             last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      bytes_sent_q, bytes_sent_d;

  logic             owner;
  logic             own_valid;
  logic [7:0]       own_data;
  logic             own_last;
  logic             issue;
  logic             winner;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  assign owner       = grant_q[1];
  assign own_valid   = owner ? req1_valid : req0_valid;
  assign own_data    = owner ? req1_data  : req0_data;
  assign own_last    = owner ? req1_last  : req0_last;
  assign issue       = (state_q == S_LOAD) && own_valid && tx_ready;
  // prio_q names the requester that wins a tie; a lone requester always wins
  assign winner      = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = tx_ready && (cnt_inc >= TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      prio_q       <= 1'b0;
      last_q       <= 1'b0;
      tx_data_q    <= 8'h00;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      bytes_sent_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      prio_q       <= prio_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (req0_valid || req1_valid) state_d = S_LOAD;
      S_LOAD:      if (issue) state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_ready || timeout_hit) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_ready) state_d = last_q ? S_IDLE : S_LOAD;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    prio_d       = prio_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    bytes_sent_d = bytes_sent_q;
    tx_en        = 1'b0;
    req0_ack     = 1'b0;
    req1_ack     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) grant_d = winner ? 2'b10 : 2'b01;
      end
      S_LOAD: begin
        if (issue) begin
          tx_en        = 1'b1;
          req0_ack     = ~owner;
          req1_ack     = owner;
          tx_data_d    = own_data;
          last_d       = own_last;
          bytes_sent_d = bytes_sent_q + 16'd1;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready && last_q) begin
          grant_d = 2'b00;
          prio_d  = ~owner;
        end
      end
      default: ;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;
  assign bytes_sent  = bytes_sent_q;

endmodule
